// File: rtl/clk_pkg.sv
// Shared clocking constants for the system clock and the DAC polling divider.
package clk_pkg;

    localparam int unsigned SYS_CLK_HZ     = 25_000_000;
    localparam int unsigned DAC_POLL_DIV_N = 18;

    function automatic int unsigned div_freq_hz(input int unsigned n);
        return SYS_CLK_HZ >> n;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// Power-of-two clock divider: free-running N-bit counter whose MSB is the divided
// clock, plus a clk_in-domain strobe in the first cycle of each divided high phase.
module clk_divider
    import clk_pkg::*;
#(
    parameter int unsigned N = DAC_POLL_DIV_N
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_div,
    output logic div_tick
);

    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] HALF = ONE << (N - 1);

    if (N < 1 || N > 31) begin : g_bad_n
        $error("clk_divider: N=%0d outside legal range 1..31", N);
    end

    if (N == DAC_POLL_DIV_N && div_freq_hz(N) != 32'd95) begin : g_bad_poll_rate
        $error("clk_divider: unexpected DAC poll rate %0d Hz", div_freq_hz(N));
    end

    logic [N-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt      <= '0;
            div_tick <= 1'b0;
        end else begin
            cnt      <= cnt + ONE;
            // Registered one cycle early so the strobe lands on the cycle cnt == HALF.
            div_tick <= (cnt == HALF - ONE);
        end
    end

    assign clk_div = cnt[N-1];

    a_div_stable: assert property (@(posedge clk_in) disable iff (rst)
        (cnt != HALF && cnt != '0) |-> $stable(clk_div));

    a_tick_implies_div: assert property (@(posedge clk_in) disable iff (rst)
        div_tick |-> clk_div);

    if (N > 1) begin : g_tick_single
        a_tick_one_cycle: assert property (@(posedge clk_in) disable iff (rst)
            div_tick |=> !div_tick);
    end

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider at several ratios against an arithmetic
// model based on the number of clk_in edges since reset was released.
module tb_clk_divider;

    localparam int unsigned NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_o  [NDUT];
    logic        tick_o [NDUT];
    int unsigned nval   [NDUT] = '{3, 1, 7, 18};

    int unsigned checks = 0;
    int unsigned passed = 0;
    longint unsigned k = 0;  // clk_in edges with rst low since the last reset edge

    always #20 clk = ~clk;

    always @(posedge clk) k <= rst ? 64'd0 : k + 64'd1;

    clk_divider #(.N(3)) u_d3 (.clk_in(clk), .rst(rst), .clk_div(div_o[0]), .div_tick(tick_o[0]));
    clk_divider #(.N(1)) u_d1 (.clk_in(clk), .rst(rst), .clk_div(div_o[1]), .div_tick(tick_o[1]));
    clk_divider #(.N(7)) u_d7 (.clk_in(clk), .rst(rst), .clk_div(div_o[2]), .div_tick(tick_o[2]));
    clk_divider u_d18 (.clk_in(clk), .rst(rst), .clk_div(div_o[3]), .div_tick(tick_o[3]));

    function automatic logic exp_div(input int unsigned n, input longint unsigned kk);
        longint unsigned p = 64'd1 << n;
        return (kk % p) >= (p / 2);
    endfunction

    function automatic logic exp_tick(input int unsigned n, input longint unsigned kk);
        longint unsigned p = 64'd1 << n;
        return (kk % p) == (p / 2);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            for (int i = 0; i < NDUT; i++) begin
                checks++;
                if (div_o[i] !== 1'b0 || tick_o[i] !== 1'b0)
                    $display("FAIL reset N=%0d: clk_div=%b div_tick=%b, required 0 0", nval[i], div_o[i], tick_o[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_n3_waveform();
        int rise_at = -1;
        int fall_at = -1;
        logic prev;
        rst  = 1'b0;
        prev = div_o[0];
        for (int c = 1; c <= 24; c++) begin
            step();
            if (rise_at < 0 && !prev && div_o[0] === 1'b1) rise_at = c;
            if (rise_at > 0 && fall_at < 0 && prev && div_o[0] === 1'b0) fall_at = c;
            prev = div_o[0];
            checks++;
            if (div_o[0] !== exp_div(3, k))
                $display("FAIL n3_wave cycle %0d: clk_div=%b, required %b", c, div_o[0], exp_div(3, k));
            else passed++;
        end
        checks++;
        if (rise_at != 4) $display("FAIL n3_first_rise: edge %0d, required 4", rise_at);
        else passed++;
        checks++;
        if (fall_at != 8) $display("FAIL n3_first_fall: edge %0d, required 8", fall_at);
        else passed++;
    endtask

    task automatic test_tick_count();
        int   pulses = 0;
        logic prev_div;
        logic prev_tick;
        rst = 1'b1;
        step();
        rst       = 1'b0;
        prev_div  = div_o[0];
        prev_tick = tick_o[0];
        for (int c = 1; c <= 80; c++) begin
            step();
            if (tick_o[0] === 1'b1) begin
                pulses++;
                checks++;
                if (prev_tick !== 1'b0 || prev_div !== 1'b0 || div_o[0] !== 1'b1)
                    $display("FAIL tick_shape cycle %0d: prev_tick=%b prev_div=%b div=%b, required 0 0 1",
                             c, prev_tick, prev_div, div_o[0]);
                else passed++;
            end
            prev_div  = div_o[0];
            prev_tick = tick_o[0];
        end
        checks++;
        if (pulses != 10) $display("FAIL tick_count: %0d pulses, required 10", pulses);
        else passed++;
    endtask

    task automatic test_n1();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (div_o[1] !== 1'(c % 2) || tick_o[1] !== div_o[1])
                $display("FAIL n1 cycle %0d: clk_div=%b div_tick=%b, required %b %b",
                         c, div_o[1], tick_o[1], 1'(c % 2), 1'(c % 2));
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        int rise   = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        while (k % 8 != 5 && waited < 16) begin
            step();
            waited++;
        end
        checks++;
        if (k % 8 != 5 || div_o[0] !== 1'b1)
            $display("FAIL mid_reset_setup: clk_div=%b after %0d cycles, required 1 at cnt=5", div_o[0], waited);
        else passed++;
        rst = 1'b1;
        step();
        checks++;
        if (div_o[0] !== 1'b0 || tick_o[0] !== 1'b0)
            $display("FAIL mid_reset_clear: clk_div=%b div_tick=%b, required 0 0", div_o[0], tick_o[0]);
        else passed++;
        rst = 1'b0;
        for (int c = 1; c <= 10 && rise < 0; c++) begin
            step();
            if (div_o[0] === 1'b1) rise = c;
        end
        checks++;
        if (rise != 4) $display("FAIL mid_reset_rise: edge %0d, required 4", rise);
        else passed++;
    endtask

    task automatic test_long_reset();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (div_o[0] !== 1'b0 || tick_o[0] !== 1'b0)
                $display("FAIL long_reset cycle %0d: clk_div=%b div_tick=%b, required 0 0", c, div_o[0], tick_o[0]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int unsigned hold = 0;
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (hold > 0) begin
                hold--;
                rst = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                hold = $urandom_range(0, 2);
                rst  = 1'b1;
            end else begin
                rst = 1'b0;
            end
            step();
            for (int i = 0; i < NDUT; i++) begin
                checks++;
                if (div_o[i] !== exp_div(nval[i], k) || tick_o[i] !== exp_tick(nval[i], k))
                    $display("FAIL random N=%0d cycle %0d: clk_div=%b div_tick=%b, required %b %b",
                             nval[i], c, div_o[i], tick_o[i], exp_div(nval[i], k), exp_tick(nval[i], k));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_n3_waveform();
        test_tick_count();
        test_n1();
        test_mid_reset();
        test_long_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
